// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory request responder driving a single-port synchronous SRAM
module data_mem_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_READ,
    S_WAIT,
    S_RESP
  } state_t;

  // Window size in bytes, one bit wider than an address so a 2^30-word SRAM still fits.
  localparam logic [32:0] SPAN      = 33'd4 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  logic        lat_unsigned;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] offset;
  logic        fault;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_rdata;

  assign offset    = lat_addr - BASE_ADDR;
  assign req_ready = (state == S_IDLE);

  // Fault decode works only from the latched request so it is stable for the whole transaction.
  always_comb begin
    fault = 1'b0;
    case (lat_size)
      2'd0:    fault = 1'b0;
      2'd1:    fault = lat_addr[0];
      2'd2:    fault = (lat_addr[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
    if (lat_addr < BASE_ADDR)
      fault = 1'b1;
    if ({1'b0, offset} >= SPAN)
      fault = 1'b1;
  end

  // Little-endian lane extraction of the SRAM word followed by sign or zero extension.
  always_comb begin
    byte_v = sram_rdata[{lat_addr[1:0], 3'b000} +: 8];
    half_v = sram_rdata[{lat_addr[1], 4'b0000} +: 16];
    case (lat_size)
      2'd0:    ext_rdata = lat_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'd1:    ext_rdata = lat_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: ext_rdata = sram_rdata;
    endcase
  end

  // SRAM is only touched in ACCESS for a non-faulting request; reset forces IDLE so enable drops at once.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = offset[ADDR_WIDTH+1:2];
    sram_wdata = lat_wdata;
    if (state == S_ACCESS && !fault) begin
      sram_en = 1'b1;
      if (lat_we) begin
        case (lat_size)
          2'd0: begin
            sram_we    = 4'b0001 << lat_addr[1:0];
            sram_wdata = {4{lat_wdata[7:0]}};
          end
          2'd1: begin
            sram_we    = 4'b0011 << {lat_addr[1], 1'b0};
            sram_wdata = {2{lat_wdata[15:0]}};
          end
          default: begin
            sram_we    = 4'b1111;
            sram_wdata = lat_wdata;
          end
        endcase
      end
    end
  end

  // Transaction sequencer: accept, access, capture, optional wait states, then hold the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wait_cnt     <= 4'd0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'd0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            state        <= S_ACCESS;
          end
        end
        S_ACCESS: state <= S_READ;
        S_READ: begin
          rsp_err   <= fault;
          rsp_rdata <= (fault || lat_we) ? 32'd0 : ext_rdata;
          if (WAIT_STATES > 0) begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_WAIT;
          end else begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the core's data-memory request/response channel. It accepts one load/store request at a time from the pipeline's MEM stage and performs byte, halfword or word access against a single-port synchronous SRAM. It returns load data already lane-extracted and sign/zero-extended, or a write acknowledge, with a configurable number of wait states. Misaligned, illegal-size and out-of-range accesses are flagged and never touch the SRAM.

Parameters:
ADDR_WIDTH, 12, SRAM word-address bits; capacity 4*2^ADDR_WIDTH bytes
BASE_ADDR, 32'h0000_0000, byte address mapped to SRAM word 0; must be 4-byte aligned
WAIT_STATES, 0, extra cycles inserted before the response (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  zero-extend load (LBU/LHU)
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access faulted
sram_en  out  1  SRAM enable
sram_we  out  4  byte write enables
sram_addr  out  ADDR_WIDTH  word address
sram_wdata  out  32  lane-replicated write data
sram_rdata  in  32  read data, valid the cycle after sram_en with sram_we = 0

Behaviour:
- Reset (reset low, async): state IDLE, wait counter 0, latched request 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, sram_en 0, sram_we 0. Requests presented while reset is low are dropped.
- Handshake: a request is accepted on a clock edge where req_valid && req_ready. All req_* fields are latched at acceptance; later changes on req_* are ignored.
- A response completes on an edge where rsp_valid && rsp_ready. rsp_valid, rsp_rdata and rsp_err hold stable until that edge.
- FSM:
  - IDLE: on acceptance, go to ACCESS.
  - ACCESS (1 cycle): drive SRAM unless the request faulted, then go to READ.
  - READ (1 cycle): capture the extended sram_rdata into rsp_rdata (loads only), then go to WAIT if WAIT_STATES > 0, else RESP.
  - WAIT: stay WAIT_STATES cycles, then go to RESP.
  - RESP: rsp_valid = 1; go to IDLE on rsp_ready.
- Latency: for a handshake in cycle k, rsp_valid is first high in cycle k+3+WAIT_STATES. Loads, stores and errors all use identical timing.
- No combinational path from req_* to sram_* or rsp_*. SRAM outputs are decoded only from the registered state and the latched request.
- Fault when any of the following holds: size == 3; half with addr[0] = 1; word with addr[1:0] != 0; addr < BASE_ADDR; or addr - BASE_ADDR >= 4*2^ADDR_WIDTH.
  - On fault: sram_en stays 0, rsp_err = 1, rsp_rdata = 0.
- SRAM drive in ACCESS:
  - sram_addr = (addr - BASE_ADDR) >> 2.
  - Store byte: sram_we = 4'b0001 << addr[1:0]; sram_wdata = {4{wdata[7:0]}}.
  - Store half: sram_we = 4'b0011 << {addr[1], 1'b0}; sram_wdata = {2{wdata[15:0]}}.
  - Store word: sram_we = 4'b1111; sram_wdata = wdata.
  - Load: sram_we = 0.
  - Outside ACCESS: sram_en = 0, sram_we = 0.
- Load extraction is little-endian:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend unless req_unsigned; req_unsigned is ignored for words.
- Store responses: rsp_rdata = 0, rsp_err = 0.
- Reset mid-operation: transaction aborted and no response is issued. A store already enabled in ACCESS remains committed in SRAM. sram_en drops asynchronously with reset.
- Back-to-back requests: the next request can be accepted no earlier than the cycle after the response handshake.

Test Plan:
1. W=0: SW 0xDEADBEEF @0x8, then LW @0x8 (handshake cycle k) -> in cycle k+1 sram_en=1, sram_we=0, sram_addr=2; rsp_valid first in cycle k+3; rsp_rdata=0xDEADBEEF, rsp_err=0.
2. SB wdata=0x80 @0x5 -> sram_we=4'b0010, sram_wdata=0x80808080, sram_addr=1. Then LB @0x5 -> 0xFFFFFF80; LBU @0x5 -> 0x00000080.
3. SW 0x1234ABCD @0x4; LH @0x6 -> 0x00001234; LH @0x4 -> 0xFFFFABCD. LH @0x3 -> rsp_err=1, rsp_rdata=0, sram_en never high.
4. WAIT_STATES=2, LW handshake in cycle k, rsp_ready held low 3 cycles -> rsp_valid from cycle k+5 with stable data; req_ready=0 until the cycle after the rsp handshake.
5. Reset pulsed low during WAIT -> rsp_valid never asserts, req_ready=1. A following LW completes normally with original SRAM contents.
6. ADDR_WIDTH=12, BASE_ADDR=0: LW @0x4000 -> rsp_err=1, no SRAM access. LW @0x3FFC -> rsp_err=0.
